// File: rtl/secure_rf_pkg.sv
// Shared types and constants for the secured register file and its key FSM.
package secure_rf_pkg;

  localparam int KEY_W  = 16;
  localparam int FAIL_W = 4;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } key_state_e;

endpackage

// File: rtl/secure_rf_keyfsm.sv
// Key-unlock FSM: counts consecutive wrong keys and locks out permanently at MAX_FAILS.
module secure_rf_keyfsm
  import secure_rf_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY       = 16'h0032,
  parameter int               MAX_FAILS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             unlock_req,
  input  logic [KEY_W-1:0] key_in,
  input  logic             relock,
  output logic             locked_o,
  output logic             lockout_o,
  output key_state_e       state_o
);

  key_state_e        state_q, state_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic              locked_q, locked_d;
  logic              lockout_q, lockout_d;

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    case (state_q)
      LOCKED: begin
        // relock outranks a same-cycle unlock attempt
        if (relock) begin
          fail_d = '0;
        end else if (unlock_req) begin
          if (key_in == KEY) begin
            state_d = UNLOCKED;
            fail_d  = '0;
          end else begin
            fail_d = fail_q + 1'b1;
            if (fail_q == FAIL_W'(MAX_FAILS - 1)) state_d = LOCKOUT;
          end
        end
      end
      UNLOCKED: begin
        if (relock) begin
          state_d = LOCKED;
          fail_d  = '0;
        end
      end
      LOCKOUT: ;
      default: begin
        state_d = LOCKED;
        fail_d  = '0;
      end
    endcase
    locked_d  = (state_d != UNLOCKED);
    lockout_d = (state_d == LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= LOCKED;
      fail_q    <= '0;
      locked_q  <= 1'b1;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fail_q    <= fail_d;
      locked_q  <= locked_d;
      lockout_q <= lockout_d;
    end
  end

  assign locked_o  = locked_q;
  assign lockout_o = lockout_q;
  assign state_o   = state_q;

endmodule

// File: rtl/secure_regfile.sv
// 2-write/3-read register file with post-reset init sweep and key-protected upper region.
// Define WRITE_BYPASS_EN to forward same-cycle accepted writes to the read ports.
module secure_regfile
  import secure_rf_pkg::*;
#(
  parameter int               DW        = 32,
  parameter int               AW        = 10,
  parameter int               PROT_BASE = 1008,
  parameter logic [KEY_W-1:0] KEY       = 16'h0032,
  parameter int               MAX_FAILS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_mem_en,
  input  logic [AW-1:0]    wr_mem_addr,
  input  logic [DW-1:0]    wr_mem_data,
  input  logic             wr_alu_en,
  input  logic [AW-1:0]    wr_alu_addr,
  input  logic [DW-1:0]    wr_alu_data,
  input  logic [AW-1:0]    rd1_addr,
  input  logic [AW-1:0]    rd2_addr,
  input  logic [AW-1:0]    rd3_addr,
  output logic [DW-1:0]    rd1_data,
  output logic [DW-1:0]    rd2_data,
  output logic [DW-1:0]    rd3_data,
  input  logic             unlock_req,
  input  logic [KEY_W-1:0] key_in,
  input  logic             relock,
  output logic             locked,
  output logic             lockout,
  output logic             ready,
  output logic             wr_violation
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] ptr_q, ptr_d;
  logic          ready_q, ready_d;
  logic          viol_q, viol_d;
  logic [DW-1:0] rd1_q, rd1_d, rd2_q, rd2_d, rd3_q, rd3_d;
  logic          mem_ok, alu_ok, mem_prot, alu_prot, open_q;
  key_state_e    key_state;

  secure_rf_keyfsm #(
    .KEY       (KEY),
    .MAX_FAILS (MAX_FAILS)
  ) u_keyfsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .unlock_req (unlock_req & ready_q),
    .key_in     (key_in),
    .relock     (relock & ready_q),
    .locked_o   (locked),
    .lockout_o  (lockout),
    .state_o    (key_state)
  );

  function automatic logic [DW-1:0] rd_value(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = mem[a];
`ifdef WRITE_BYPASS_EN
    if (mem_ok && wr_mem_addr == a) v = wr_mem_data;
    if (alu_ok && wr_alu_addr == a) v = wr_alu_data;
`endif
    return v;
  endfunction

  always_comb begin
    open_q   = (key_state == UNLOCKED);
    mem_prot = (wr_mem_addr >= AW'(PROT_BASE));
    alu_prot = (wr_alu_addr >= AW'(PROT_BASE));
    mem_ok   = ready_q && wr_mem_en && (!mem_prot || open_q);
    alu_ok   = ready_q && wr_alu_en && (!alu_prot || open_q);
    viol_d   = ready_q && !open_q &&
               ((wr_mem_en && mem_prot) || (wr_alu_en && alu_prot));

    ptr_d   = ptr_q;
    ready_d = ready_q;
    if (!ready_q) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == AW'(DEPTH - 1)) ready_d = 1'b1;
    end

    rd1_d = '0;
    rd2_d = '0;
    rd3_d = '0;
    if (ready_q) begin
      rd1_d = rd_value(rd1_addr);
      rd2_d = rd_value(rd2_addr);
      rd3_d = rd_value(rd3_addr);
    end
  end

  // Storage has no reset; the sweep loads mem[i] = i before any port op is honoured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      ready_q <= 1'b0;
      viol_q  <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rd3_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      viol_q  <= viol_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      rd3_q   <= rd3_d;
      if (!ready_q) mem[ptr_q] <= DW'(ptr_q);
      if (mem_ok)   mem[wr_mem_addr] <= wr_mem_data;
      if (alu_ok)   mem[wr_alu_addr] <= wr_alu_data;
    end
  end

  assign ready        = ready_q;
  assign wr_violation = viol_q;
  assign rd1_data     = rd1_q;
  assign rd2_data     = rd2_q;
  assign rd3_data     = rd3_q;

endmodule

// File: tb/tb_secure_regfile.sv
// Directed self-checking bench for secure_regfile (follows WRITE_BYPASS_EN for the bypass case).
module tb_secure_regfile;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_mem_en, wr_alu_en;
  logic [AW-1:0] wr_mem_addr, wr_alu_addr;
  logic [DW-1:0] wr_mem_data, wr_alu_data;
  logic [AW-1:0] rd1_addr, rd2_addr, rd3_addr;
  logic [DW-1:0] rd1_data, rd2_data, rd3_data;
  logic          unlock_req, relock;
  logic [15:0]   key_in;
  logic          locked, lockout, ready, wr_violation;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  secure_regfile dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_mem_en    (wr_mem_en),
    .wr_mem_addr  (wr_mem_addr),
    .wr_mem_data  (wr_mem_data),
    .wr_alu_en    (wr_alu_en),
    .wr_alu_addr  (wr_alu_addr),
    .wr_alu_data  (wr_alu_data),
    .rd1_addr     (rd1_addr),
    .rd2_addr     (rd2_addr),
    .rd3_addr     (rd3_addr),
    .rd1_data     (rd1_data),
    .rd2_data     (rd2_data),
    .rd3_data     (rd3_data),
    .unlock_req   (unlock_req),
    .key_in       (key_in),
    .relock       (relock),
    .locked       (locked),
    .lockout      (lockout),
    .ready        (ready),
    .wr_violation (wr_violation)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; all drives and samples happen 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_mem_en = 0; wr_mem_addr = '0; wr_mem_data = '0;
    wr_alu_en = 0; wr_alu_addr = '0; wr_alu_data = '0;
    unlock_req = 0; relock = 0; key_in = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic wait_sweep(input string tag);
    repeat (DEPTH - 1) tick();
    check({tag, "_ready_lo"}, {31'd0, ready}, 32'd0);
    tick();
    check({tag, "_ready_hi"}, {31'd0, ready}, 32'd1);
  endtask

  task automatic write(input logic me, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input logic ae, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
    wr_mem_en = me; wr_mem_addr = ma; wr_mem_data = md;
    wr_alu_en = ae; wr_alu_addr = aa; wr_alu_data = ad;
    tick();
    wr_mem_en = 0; wr_alu_en = 0;
  endtask

  task automatic read1(input logic [AW-1:0] a, input string tag, input logic [DW-1:0] exp);
    rd1_addr = a;
    tick();
    check(tag, rd1_data, exp);
  endtask

  task automatic unlock(input logic [15:0] k);
    unlock_req = 1; key_in = k;
    tick();
    unlock_req = 0;
  endtask

  initial begin
    idle_inputs();
    rd1_addr = '0; rd2_addr = '0; rd3_addr = '0;
    rst_n = 0;
    tick();
    tick();
    check("rst_rd1", rd1_data, 32'd0);
    check("rst_rd3", rd3_data, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd1);
    check("rst_lockout", {31'd0, lockout}, 32'd0);
    check("rst_viol", {31'd0, wr_violation}, 32'd0);
    rst_n = 1;
    wait_sweep("t1");

    // 1: init contents
    rd1_addr = 10'd5; rd2_addr = 10'd1023;
    tick();
    check("t1_rd1", rd1_data, 32'd5);
    check("t1_rd2", rd2_data, 32'd1023);

    // 2: dual write same address, ALU wins
    write(1, 10'd7, 32'hAAAA, 1, 10'd7, 32'h5555);
    read1(10'd7, "t2_alu_wins", 32'h5555);

    // 3: protection
    write(0, '0, '0, 1, 10'd1010, 32'hDEAD);
    check("t3_viol_pulse", {31'd0, wr_violation}, 32'd1);
    tick();
    check("t3_viol_clear", {31'd0, wr_violation}, 32'd0);
    read1(10'd1010, "t3_dropped", 32'd1010);
    write(1, 10'd1020, 32'h1, 1, 10'd1021, 32'h2);
    check("t3_dual_viol", {31'd0, wr_violation}, 32'd1);
    tick();
    check("t3_dual_single", {31'd0, wr_violation}, 32'd0);
    unlock(16'h0032);
    check("t3_unlocked", {31'd0, locked}, 32'd0);
    write(0, '0, '0, 1, 10'd1010, 32'hDEAD);
    check("t3_no_viol", {31'd0, wr_violation}, 32'd0);
    read1(10'd1010, "t3_landed", 32'hDEAD);
    relock = 1;
    tick();
    relock = 0;
    check("t3_relocked", {31'd0, locked}, 32'd1);

    // 4: lockout after three wrong keys
    unlock(16'h0000); tick();
    unlock(16'h0000); tick();
    check("t4_not_yet", {31'd0, lockout}, 32'd0);
    unlock(16'h0000);
    check("t4_lockout", {31'd0, lockout}, 32'd1);
    check("t4_locked", {31'd0, locked}, 32'd1);
    unlock(16'h0032);
    check("t4_key_rejected", {31'd0, locked}, 32'd1);
    relock = 1; tick(); relock = 0;
    check("t4_relock_ignored", {31'd0, lockout}, 32'd1);
    write(0, '0, '0, 1, 10'd1015, 32'hBAD);
    check("t4_viol", {31'd0, wr_violation}, 32'd1);
    do_reset();
    check("t4_rst_lockout", {31'd0, lockout}, 32'd0);
    wait_sweep("t4");
    unlock(16'h0032);
    check("t4_unlock_after_rst", {31'd0, locked}, 32'd0);
    read1(10'd1010, "t4_reinit", 32'd1010);

    // 5: same-cycle read/write
    rd3_addr = 10'd3;
    write(1, 10'd3, 32'h1234, 0, '0, '0);
`ifdef WRITE_BYPASS_EN
    check("t5_bypass", rd3_data, 32'h1234);
`else
    check("t5_old", rd3_data, 32'd3);
`endif
    tick();
    check("t5_new", rd3_data, 32'h1234);
    write(0, '0, '0, 1, 10'd500, 32'hBEEF);
    read1(10'd500, "t5_beef", 32'hBEEF);

    // 6: reset mid-sweep at index 300
    rd1_addr = 10'd3; rd2_addr = 10'd500;
    do_reset();
    repeat (300) tick();
    check("t6_rd_held0", rd1_data, 32'd0);
    rst_n = 0;
    tick();
    rst_n = 1;
    wait_sweep("t6");
    tick();
    check("t6_mem3", rd1_data, 32'd3);
    check("t6_mem500", rd2_data, 32'd500);
    check("t6_locked", {31'd0, locked}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
